// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and baud divisor helper,
// common to uart_receiver and uart_transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Integer clocks per bit; callers require a result of at least 4.
    function automatic int unsigned clks_per_bit(input int unsigned clock_rate,
                                                 input int unsigned baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small registered FIFO for received bytes. Push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_reg [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg;
    logic [DEPTH_BITS-1:0] rd_ptr_reg;
    logic [DEPTH_BITS:0]   count_reg;
    logic [DEPTH-1:0]      wr_en;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_COUNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == DEPTH_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= push_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its centre and
// queues good bytes in a FIFO, with sticky framing/overflow flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE      = 100000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned FIFO_DEPTH_BITS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] read_data,
    output logic       data_available,
    input  logic       read_req,
    output logic       framing_error,
    output logic       overflow,
    input  logic       clear_errors
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned TIMER_W      = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);

    logic [1:0]         sync_reg;
    logic               rx_s;
    rx_state_t          state_reg,  state_next;
    logic [TIMER_W-1:0] timer_reg,  timer_next;
    logic [2:0]         index_reg,  index_next;
    logic [7:0]         shift_reg,  shift_next;
    logic               framing_error_reg, framing_error_next;
    logic               overflow_reg,      overflow_next;
    logic               push;
    logic               stop_bad;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg          <= 2'b11;
            state_reg         <= IDLE;
            timer_reg         <= '0;
            index_reg         <= '0;
            shift_reg         <= '0;
            framing_error_reg <= 1'b0;
            overflow_reg      <= 1'b0;
        end else begin
            sync_reg          <= {sync_reg[0], rx};
            state_reg         <= state_next;
            timer_reg         <= timer_next;
            index_reg         <= index_next;
            shift_reg         <= shift_next;
            framing_error_reg <= framing_error_next;
            overflow_reg      <= overflow_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        index_next = index_reg;
        shift_next = shift_reg;
        push       = 1'b0;
        stop_bad   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    timer_next = '0;
                end
            end
            START: begin
                if (timer_reg == HALF_LAST) begin
                    timer_next = '0;
                    index_next = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DATA: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (index_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        index_next = index_reg + 3'd1;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a new start edge follow directly.
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    state_next = IDLE;
                    push       = rx_s;
                    stop_bad   = ~rx_s;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // A full FIFO only makes room when the reader pops in the same cycle.
    assign drop = push & fifo_full & ~read_req;

    always_comb begin
        framing_error_next = (framing_error_reg & ~clear_errors) | stop_bad;
        overflow_next      = (overflow_reg & ~clear_errors) | drop;
    end

    uart_rx_fifo #(
        .WIDTH      (8),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (shift_reg),
        .pop       (read_req),
        .head      (read_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_available = ~fifo_empty;
    assign framing_error  = framing_error_reg;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit: vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int C = 16;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b1;
    logic       rx           = 1'b1;
    logic       read_req     = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] read_data;
    logic       data_available;
    logic       framing_error;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    logic [7:0] popped;

    logic [7:0] model_q[$];
    logic       exp_fe;
    logic       exp_ov;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_avail;
        logic       exp_fe;
    } vec_t;
    vec_t vecs[6];

    uart_receiver #(
        .CLOCK_RATE      (16),
        .BAUD_RATE       (1),
        .FIFO_DEPTH_BITS (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx             (rx),
        .read_data      (read_data),
        .data_available (data_available),
        .read_req       (read_req),
        .framing_error  (framing_error),
        .overflow       (overflow),
        .clear_errors   (clear_errors)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller is at a negedge; returns at a negedge right after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop;
        repeat (C) @(negedge clk);
        rx = 1'b1;
        $display("frame sent: data=0x%02h stop=%0d", b, stop);
    endtask

    task automatic do_read(input string name, input logic [7:0] exp);
        check1({name, "_avail"}, data_available, 1'b1);
        check8({name, "_data"}, read_data, exp);
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    // Reference model: frame outcome decided from the stop bit and occupancy.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) begin
            exp_fe = 1'b1;
        end else if (model_q.size() < 4) begin
            model_q.push_back(b);
        end else begin
            exp_ov = 1'b1;
        end
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b1};

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check1("reset_avail", data_available, 1'b0);
        check8("reset_data", read_data, 8'h00);
        check1("reset_fe", framing_error, 1'b0);
        check1("reset_ov", overflow, 1'b0);
        reset_n = 1'b1;
        idle(4);

        // First frame with latency measured from the rx falling edge.
        lat = 400;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int i = 1; i <= 400; i++) begin
                    @(negedge clk);
                    if (data_available) begin
                        lat = i;
                        break;
                    end
                end
            end
        join
        $display("latency to data_available: %0d cycles", lat);
        check1("latency_0x55", (lat >= 154) && (lat <= 156), 1'b1);
        do_read("first_0x55", 8'h55);
        check1("first_empty_after_read", data_available, 1'b0);
        check1("first_fe", framing_error, 1'b0);
        check1("first_ov", overflow, 1'b0);
        idle(4);

        foreach (vecs[k]) begin
            send_frame(vecs[k].data, vecs[k].stop);
            idle(4);
            check1("vec_avail", data_available, vecs[k].exp_avail);
            check1("vec_fe", framing_error, vecs[k].exp_fe);
            check1("vec_ov", overflow, 1'b0);
            if (vecs[k].exp_avail) begin
                do_read("vec_read", vecs[k].data);
                check1("vec_empty_after_read", data_available, 1'b0);
            end
            if (vecs[k].exp_fe) begin
                pulse_clear();
                check1("vec_fe_cleared", framing_error, 1'b0);
            end
            idle(2 * C);
        end

        // Short low glitch must be rejected without any flag.
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(10);
        check1("glitch_idle", dut.state_reg == IDLE, 1'b1);
        check1("glitch_avail", data_available, 1'b0);
        check1("glitch_fe", framing_error, 1'b0);
        idle(2 * C);

        // Set event coinciding with clear_errors keeps the flag set.
        fork
            send_frame(8'h5A, 1'b0);
            begin
                idle(154);
                clear_errors = 1'b1;
                @(negedge clk);
                clear_errors = 1'b0;
            end
        join
        check1("set_wins_fe", framing_error, 1'b1);
        pulse_clear();
        check1("set_wins_fe_cleared", framing_error, 1'b0);
        idle(2 * C);

        // Overflow: five frames into a four-entry FIFO with no reads.
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1);
            idle(3);
            if (k == 4) check1("ovf_before_5th", overflow, 1'b0);
        end
        check1("ovf_after_5th", overflow, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            do_read("ovf_read", 8'(k));
        end
        check1("ovf_drained", data_available, 1'b0);
        pulse_clear();
        check1("ovf_cleared", overflow, 1'b0);

        // Back-to-back frames; pop lands on the second push while full.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        popped = 8'h00;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                idle(314);
                popped = read_data;
                read_req = 1'b1;
                @(negedge clk);
                read_req = 1'b0;
            end
        join
        check8("b2b_popped", popped, 8'h11);
        check1("b2b_ov", overflow, 1'b0);
        do_read("b2b_read", 8'h22);
        do_read("b2b_read", 8'h33);
        do_read("b2b_read", 8'h00);
        do_read("b2b_read", 8'hFF);
        check1("b2b_drained", data_available, 1'b0);

        // Asynchronous reset in the middle of a frame.
        send_frame(8'h77, 1'b1);
        send_frame(8'h12, 1'b0);
        idle(C);
        rx = 1'b0;
        idle(3 * C);
        #2 reset_n = 1'b0;
        #1;
        check1("arst_avail", data_available, 1'b0);
        check8("arst_data", read_data, 8'h00);
        check1("arst_fe", framing_error, 1'b0);
        check1("arst_ov", overflow, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        idle(2);
        reset_n = 1'b1;
        idle(4);
        send_frame(8'h3C, 1'b1);
        idle(2);
        do_read("arst_next", 8'h3C);
        check1("arst_next_empty", data_available, 1'b0);
        check1("arst_next_fe", framing_error, 1'b0);
        idle(C);

        // Randomized frames, reads and clears against the queue model.
        model_q.delete();
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            logic       stop;
            int         nr;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(b, stop);
            model_frame(b, stop);
            idle(stop ? $urandom_range(1, 3) : C);
            check1("rand_avail", data_available, model_q.size() != 0);
            check1("rand_fe", framing_error, exp_fe);
            check1("rand_ov", overflow, exp_ov);
            nr = $urandom_range(0, model_q.size());
            for (int r = 0; r < nr; r++) begin
                do_read("rand_read", model_q.pop_front());
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
                exp_fe = 1'b0;
                exp_ov = 1'b0;
            end
        end
        while (model_q.size() != 0) begin
            do_read("rand_drain", model_q.pop_front());
        end
        check1("rand_final_empty", data_available, 1'b0);

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receive path: the inbound counterpart of uart_transmitter.
- Synchronises the rx pin, detects and validates start bits, and samples each bit at its centre.
- Pushes received bytes into a small FIFO that a bus-facing interface block (future uart_receiver_interface behind mem_mapper) drains with read_req.
- Flags framing errors and FIFO overflow as sticky status bits.

Parameters:
CLOCK_RATE, 100000000, clk frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE (integer division, must be >= 4)
FIFO_DEPTH_BITS, 2, log2 of FIFO depth (default 4 entries)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
read_data  output  8  FIFO head byte; valid only while data_available=1
data_available  output  1  FIFO non-empty
read_req  input  1  pop FIFO head this cycle; ignored when empty
framing_error  output  1  sticky: stop bit sampled 0
overflow  output  1  sticky: byte dropped because FIFO full
clear_errors  input  1  clears both sticky flags

Behaviour:
- Reset (async assert, sync deassert use): synchroniser flops=1, state IDLE, counters=0, FIFO empty, read_data=0, data_available=0, framing_error=0, overflow=0.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only.
- FSM states IDLE, START, DATA, STOP; one bit-timer counter (0..CLKS_PER_BIT-1), 3-bit index, 8-bit shift register.
- IDLE: rx_s=0 -> START, timer=0.
- START: at timer = CLKS_PER_BIT/2 - 1, sample rx_s. If 0 -> DATA, timer=0, index=0. If 1 -> IDLE (glitch rejected, no flag).
- DATA: at timer = CLKS_PER_BIT-1, sample rx_s into shift register MSB and shift right, so the first bit received ends in bit 0 (LSB first). Timer wraps to 0. When index=7 at the sample -> STOP; otherwise index+1.
- STOP: at timer = CLKS_PER_BIT-1, sample rx_s, then -> IDLE in the same cycle.
  - Sample 1: push the byte.
  - Sample 0: discard the byte, set framing_error.
  - Returning to IDLE at mid-stop-bit allows back-to-back frames with zero idle time.
- Push rule: accepted if FIFO not full, or if full and read_req pops in the same cycle. Otherwise the byte is dropped and overflow is set.
- FIFO is registered. A push is visible on data_available/read_data the next cycle.
- read_req with data_available=1 advances head next cycle. Simultaneous push+pop keeps the count unchanged.
- Pointers are FIFO_DEPTH_BITS wide and wrap modulo depth. Full/empty are distinguished by a count register of FIFO_DEPTH_BITS+1 bits.
- Sticky flags: clear_errors clears next cycle. A set event in the same cycle as clear_errors wins (flag stays 1).
- Latency: data_available rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge (±1 for synchroniser phase).
- No parity, no break detection, no baud auto-detect.

Decomposition:
- Package uart_pkg holds the rx state enum (IDLE/START/DATA/STOP) and a shared clks_per_bit function, also usable by uart_transmitter.
- One sub-module, uart_rx_fifo: parameterised by width and FIFO_DEPTH_BITS; provides push/pop/full/empty/head.
- The FSM and synchroniser stay in uart_receiver.

Test Plan:
- Run the bench with CLOCK_RATE=16, BAUD_RATE=1, so CLKS_PER_BIT=16.
- Send 0x55 -> data_available=1 within ±1 of the computed latency, read_data=0x55. Pulse read_req -> data_available=0 next cycle, flags stay 0.
- Drive rx low for 4 cycles, then high -> no push, framing_error=0, FSM back in IDLE before 8+2 cycles.
- Send 0xA3 with stop bit 0 -> FIFO stays empty, framing_error=1. Pulse clear_errors -> framing_error=0 next cycle.
- Send 0x01..0x05 with no reads (depth 4) -> overflow=1 after the 5th frame. Four reads return 01, 02, 03, 04, then data_available=0.
- Send 0x00 then 0xFF with no idle between frames, and a pop coinciding with the second push while full -> both bytes received in order, overflow=0.
- Assert reset_n=0 mid-DATA of a frame -> all outputs return to reset values immediately. Next clean frame 0x3C is received correctly.
